// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: mult/div FSM encoding,
// the default mult/div latency and the saturation limit of the performance counters.
package hazard_pkg;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } md_state_e;

   localparam int unsigned MULDIV_CYCLES_DEFAULT = 32;
   localparam int unsigned MD_CNT_W              = 6;
   localparam logic [15:0] PERF_MAX              = 16'hFFFF;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at its maximum value instead of wrapping.
// Cleared asynchronously by the active-low reset.
module sat_counter16
   import hazard_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en_i,
   output logic [15:0] count_o
);

   logic [15:0] count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (en_i && (count_q != PERF_MAX)) begin
         count_q <= count_q + 16'd1;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use and mult/div stalls plus
// taken-branch flush. Performance counters exist only when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned MULDIV_CYCLES = MULDIV_CYCLES_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic        id_uses_hilo,
   input  logic [4:0]  ex_rt,
   input  logic        ex_mem_read,
   input  logic        ex_branch_taken,
   input  logic        ex_muldiv_start,
   output logic        pc_write,
   output logic        if_id_write,
   output logic        id_ex_bubble,
   output logic        if_id_flush,
   output logic        md_busy,
   output logic [15:0] stall_cnt,
   output logic [15:0] flush_cnt
);

   localparam logic [MD_CNT_W-1:0] MD_LOAD = MD_CNT_W'(MULDIV_CYCLES - 1);

   md_state_e           state_q;
   logic [MD_CNT_W-1:0] mdCnt_q;
   logic                loadUse;
   logic                mdHazard;
   logic                stall;

   // A start seen while already busy is dropped; a taken branch never aborts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RUN;
         mdCnt_q <= '0;
      end else begin
         case (state_q)
            RUN: begin
               if (ex_muldiv_start) begin
                  state_q <= MD_BUSY;
                  mdCnt_q <= MD_LOAD;
               end
            end
            MD_BUSY: begin
               if (mdCnt_q == '0) begin
                  state_q <= RUN;
               end else begin
                  mdCnt_q <= mdCnt_q - 1'b1;
               end
            end
         endcase
      end
   end

   assign md_busy  = (state_q == MD_BUSY);
   assign loadUse  = ex_mem_read && (ex_rt != 5'd0) &&
                     ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
   assign mdHazard = md_busy && id_uses_hilo;
   assign stall    = (loadUse || mdHazard) && !ex_branch_taken;

   // A taken branch squashes both the fetched and the decoded instruction, so it wins over any stall.
   always_comb begin
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_bubble = 1'b0;
      if_id_flush  = 1'b0;
      if (ex_branch_taken) begin
         if_id_flush  = 1'b1;
         id_ex_bubble = 1'b1;
      end else if (stall) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_bubble = 1'b1;
      end
   end

`ifdef HAZARD_PERF_EN
   sat_counter16 u_stall_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (stall),
      .count_o (stall_cnt)
   );

   sat_counter16 u_flush_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (ex_branch_taken),
      .count_o (flush_cnt)
   );
`else
   assign stall_cnt = 16'd0;
   assign flush_cnt = 16'd0;
`endif

endmodule
